// File: rtl/sel_sequencer.sv
// sel_sequencer: steps a 2-bit select code through all four values.
// Each code is held for a programmable dwell and then offered with a
// valid/ready handshake. The 4-code pass repeats 'loops' extra times,
// after which 'done' pulses for one cycle.
// Build option: define SEL_SEQ_GRAY_EN for Gray-coded select output
// (00,01,11,10). When it is undefined the output is plain binary (00,01,10,11).
module sel_sequencer #(
  parameter int DWELL_W = 4,
  parameter int LOOP_W  = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  input  logic [DWELL_W-1:0] dwell,
  input  logic [LOOP_W-1:0]  loops,
  output logic [1:0]         A,
  output logic               valid,
  input  logic               ready,
  output logic               busy,
  output logic               done
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'b00,
    S_WAIT    = 2'b01,
    S_PRESENT = 2'b10,
    S_DONE    = 2'b11
  } state_t;

  // Map a pass index onto the code driven to the decoder.
  function automatic logic [1:0] sel_code(input logic [1:0] idx);
`ifdef SEL_SEQ_GRAY_EN
    return idx ^ {1'b0, idx[1]};
`else
    return idx;
`endif
  endfunction

  state_t              state_q;
  logic [1:0]          idx_q;
  logic [DWELL_W-1:0]  dcnt_q;
  logic [DWELL_W-1:0]  dwell_lat_q;
  logic [LOOP_W-1:0]   lcnt_q;
  logic [1:0]          a_q;
  logic                valid_q;
  logic                busy_q;
  logic                done_q;

  logic [1:0]          idx_d;
  logic [1:0]          a_d;
  logic                last_idx_s;

  // Next index/code used when a transfer advances within a pass.
  always_comb begin
    idx_d      = idx_q + 2'd1;
    a_d        = sel_code(idx_d);
    last_idx_s = (idx_q == 2'd3);
  end

  // Sequencer state machine; all outputs are registered here.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      idx_q       <= 2'd0;
      dcnt_q      <= {DWELL_W{1'b0}};
      dwell_lat_q <= {DWELL_W{1'b0}};
      lcnt_q      <= {LOOP_W{1'b0}};
      a_q         <= 2'b00;
      valid_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else if (abort && (state_q != S_IDLE)) begin
      // abort wins over any transfer in the same cycle and never reports done
      state_q <= S_IDLE;
      idx_q   <= 2'd0;
      dcnt_q  <= {DWELL_W{1'b0}};
      lcnt_q  <= {LOOP_W{1'b0}};
      a_q     <= 2'b00;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start && !abort) begin
            state_q     <= S_WAIT;
            dcnt_q      <= dwell;
            dwell_lat_q <= dwell;
            lcnt_q      <= loops;
            idx_q       <= 2'd0;
            a_q         <= sel_code(2'd0);
            busy_q      <= 1'b1;
            valid_q     <= 1'b0;
            done_q      <= 1'b0;
          end else begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
          end
        end
        S_WAIT: begin
          if (dcnt_q == {DWELL_W{1'b0}}) begin
            state_q <= S_PRESENT;
            valid_q <= 1'b1;
          end else begin
            dcnt_q <= dcnt_q - DWELL_W'(1);
          end
        end
        S_PRESENT: begin
          if (ready) begin
            valid_q <= 1'b0;
            if (!last_idx_s) begin
              state_q <= S_WAIT;
              idx_q   <= idx_d;
              a_q     <= a_d;
              dcnt_q  <= dwell_lat_q;
            end else if (lcnt_q != {LOOP_W{1'b0}}) begin
              // end of a pass with passes remaining: restart at code 0
              state_q <= S_WAIT;
              idx_q   <= 2'd0;
              a_q     <= sel_code(2'd0);
              lcnt_q  <= lcnt_q - LOOP_W'(1);
              dcnt_q  <= dwell_lat_q;
            end else begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end
          end else begin
            valid_q <= 1'b1;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          idx_q   <= 2'd0;
          a_q     <= 2'b00;
        end
        default: begin
          state_q <= S_IDLE;
          idx_q   <= 2'd0;
          a_q     <= 2'b00;
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign A     = a_q;
  assign valid = valid_q;
  assign busy  = busy_q;
  assign done  = done_q;

endmodule

// File: tb/tb_sel_sequencer.sv
// Self-checking bench for sel_sequencer. Expected select codes are pushed
// to a scoreboard queue when a sequence is started and popped on each
// accepted transfer. Build with SEL_SEQ_GRAY_EN to check the Gray order.
module tb_sel_sequencer;

  logic       clk;
  logic       rst;
  logic       start;
  logic       abort;
  logic [3:0] dwell;
  logic [3:0] loops;
  logic [1:0] A;
  logic       valid;
  logic       ready;
  logic       busy;
  logic       done;

  int pass_cnt;
  int total_cnt;
  logic [1:0] exp_q[$];

  sel_sequencer #(.DWELL_W(4), .LOOP_W(4)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .dwell(dwell), .loops(loops), .A(A), .valid(valid),
    .ready(ready), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected code for pass index i, written as an explicit table.
  function automatic logic [1:0] exp_code(input int i);
`ifdef SEL_SEQ_GRAY_EN
    case (i)
      0: return 2'b00;
      1: return 2'b01;
      2: return 2'b11;
      default: return 2'b10;
    endcase
`else
    case (i)
      0: return 2'b00;
      1: return 2'b01;
      2: return 2'b10;
      default: return 2'b11;
    endcase
`endif
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; abort = 1'b0; ready = 1'b0;
    dwell = 4'd0; loops = 4'd0;
    cyc(); cyc(); cyc();
    rst = 1'b0;
    cyc();
    total_cnt++;
    if (A !== 2'b00) $display("FAIL reset_A: got %b expected 00", A); else pass_cnt++;
    total_cnt++;
    if (valid !== 1'b0) $display("FAIL reset_valid: got %b expected 0", valid); else pass_cnt++;
    total_cnt++;
    if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else pass_cnt++;
    total_cnt++;
    if (done !== 1'b0) $display("FAIL reset_done: got %b expected 0", done); else pass_cnt++;
  endtask

  // Full sequence with optional random backpressure; checks order, dwell gaps,
  // stall stability, transfer count, the single done pulse and return to idle.
  task automatic test_sequence(input int dw, input int lp, input int stall_pct, input string nm);
    int cyc_n, xfers, gap;
    logic prev_stall, got_done;
    logic [1:0] prev_a, last_acc;
    logic [1:0] e;
    exp_q.delete();
    for (int p = 0; p <= lp; p++)
      for (int i = 0; i < 4; i++) exp_q.push_back(exp_code(i));
    dwell = 4'(dw); loops = 4'(lp); ready = 1'b0; start = 1'b1;
    cyc();
    start = 1'b0;
    dwell = ~4'(dw); loops = ~4'(lp);   // must not affect the running sequence
    cyc_n = 0; xfers = 0; gap = 0; prev_stall = 1'b0; got_done = 1'b0;
    prev_a = 2'b00; last_acc = 2'b00;
    while (!got_done && cyc_n < 3000) begin
      if (done) begin
        got_done = 1'b1;
      end else begin
        if (prev_stall) begin
          total_cnt++;
          if (valid !== 1'b1 || A !== prev_a)
            $display("FAIL %s_stall_hold: got valid=%b A=%b expected valid=1 A=%b", nm, valid, A, prev_a);
          else pass_cnt++;
        end
        if (valid) begin
          if (!prev_stall) begin
            total_cnt++;
            if (gap !== dw + 1) $display("FAIL %s_dwell_gap: got %0d expected %0d", nm, gap, dw + 1);
            else pass_cnt++;
          end
          ready = ($urandom_range(99) >= stall_pct);
          if (ready) begin
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 2'bxx;
            total_cnt++;
            if (A !== e) $display("FAIL %s_code[%0d]: got %b expected %b", nm, xfers, A, e);
            else pass_cnt++;
`ifdef SEL_SEQ_GRAY_EN
            if (xfers > 0) begin
              total_cnt++;
              if ($countones(A ^ last_acc) != 1)
                $display("FAIL %s_gray_step: got %b after %b expected one bit change", nm, A, last_acc);
              else pass_cnt++;
            end
`endif
            last_acc = A;
            xfers++; gap = 0; prev_stall = 1'b0;
          end else begin
            prev_stall = 1'b1;
          end
          prev_a = A;
        end else begin
          gap++;
          prev_stall = 1'b0;
          ready = $urandom_range(1) == 1;
        end
        cyc();
        cyc_n++;
      end
    end
    total_cnt++;
    if (!got_done) $display("FAIL %s_done_timeout: got no done expected done within 3000 cycles", nm);
    else pass_cnt++;
    total_cnt++;
    if (xfers !== 4 * (lp + 1)) $display("FAIL %s_xfer_count: got %0d expected %0d", nm, xfers, 4 * (lp + 1));
    else pass_cnt++;
    total_cnt++;
    if (busy !== 1'b1 || valid !== 1'b0)
      $display("FAIL %s_done_state: got busy=%b valid=%b expected busy=1 valid=0", nm, busy, valid);
    else pass_cnt++;
    ready = 1'b0;
    cyc();
    total_cnt++;
    if (done !== 1'b0 || busy !== 1'b0 || A !== 2'b00)
      $display("FAIL %s_after_done: got done=%b busy=%b A=%b expected 0 0 00", nm, done, busy, A);
    else pass_cnt++;
  endtask

  task automatic test_stall();
    int n;
    dwell = 4'd3; loops = 4'd0; ready = 1'b0; start = 1'b1;
    cyc();
    start = 1'b0;
    n = 0;
    while (!valid && n < 20) begin cyc(); n++; end
    total_cnt++;
    if (n !== 4 || A !== exp_code(0)) $display("FAIL stall_first_valid: got %0d edges A=%b expected 4 edges A=%b", n, A, exp_code(0));
    else pass_cnt++;
    ready = 1'b1; cyc(); ready = 1'b0;
    n = 0;
    while (!valid && n < 20) begin cyc(); n++; end
    total_cnt++;
    if (n !== 4 || A !== exp_code(1)) $display("FAIL stall_second_valid: got %0d edges A=%b expected 4 edges A=%b", n, A, exp_code(1));
    else pass_cnt++;
    for (int i = 0; i < 5; i++) begin
      cyc();
      total_cnt++;
      if (valid !== 1'b1 || A !== exp_code(1))
        $display("FAIL stall_hold[%0d]: got valid=%b A=%b expected 1 %b", i, valid, A, exp_code(1));
      else pass_cnt++;
    end
    ready = 1'b1; cyc(); ready = 1'b0;
    n = 0;
    while (!valid && n < 20) begin cyc(); n++; end
    total_cnt++;
    if (n !== 4 || A !== exp_code(2)) $display("FAIL stall_after_accept: got %0d edges A=%b expected 4 edges A=%b", n, A, exp_code(2));
    else pass_cnt++;
    abort = 1'b1; cyc(); abort = 1'b0;
    total_cnt++;
    if (busy !== 1'b0 || valid !== 1'b0) $display("FAIL stall_cleanup: got busy=%b valid=%b expected 0 0", busy, valid);
    else pass_cnt++;
  endtask

  task automatic test_abort(input bit use_rst, input string nm);
    int n;
    logic saw_done;
    dwell = 4'd0; loops = 4'd0; ready = 1'b1; start = 1'b1;
    cyc();
    start = 1'b0;
    n = 0;
    while (!(valid && A === exp_code(2)) && n < 30) begin cyc(); n++; end
    total_cnt++;
    if (n >= 30) $display("FAIL %s_reach_code2: got timeout expected valid at A=%b", nm, exp_code(2));
    else pass_cnt++;
    if (use_rst) rst = 1'b1; else abort = 1'b1;
    cyc();
    rst = 1'b0; abort = 1'b0;
    total_cnt++;
    if (A !== 2'b00 || valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0)
      $display("FAIL %s_idle: got A=%b valid=%b busy=%b done=%b expected 00 0 0 0", nm, A, valid, busy, done);
    else pass_cnt++;
    saw_done = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cyc();
      if (done || busy || valid) saw_done = 1'b1;
    end
    total_cnt++;
    if (saw_done !== 1'b0) $display("FAIL %s_stays_idle: got activity expected none", nm);
    else pass_cnt++;
    ready = 1'b0;
  endtask

  task automatic test_start_ignored();
    int n;
    start = 1'b1; abort = 1'b1; dwell = 4'd0; loops = 4'd0;
    cyc();
    start = 1'b0; abort = 1'b0;
    total_cnt++;
    if (busy !== 1'b0) $display("FAIL abort_beats_start: got busy=%b expected 0", busy);
    else pass_cnt++;
    dwell = 4'd5; ready = 1'b0; start = 1'b1;
    cyc();
    start = 1'b0;
    cyc(); cyc();
    dwell = 4'd0; start = 1'b1;
    cyc();
    start = 1'b0;
    n = 3;
    while (!valid && n < 30) begin cyc(); n++; end
    total_cnt++;
    if (n !== 6) $display("FAIL start_while_busy: got first valid after %0d edges expected 6", n);
    else pass_cnt++;
    abort = 1'b1; cyc(); abort = 1'b0;
    total_cnt++;
    if (busy !== 1'b0) $display("FAIL start_cleanup: got busy=%b expected 0", busy);
    else pass_cnt++;
  endtask

  initial begin
    pass_cnt = 0;
    total_cnt = 0;
    test_reset();
    test_sequence(0, 0, 0, "single_pass");
    test_stall();
    test_sequence(1, 2, 0, "loops");
    test_sequence(3, 1, 40, "backpressure");
    test_abort(1'b0, "abort");
    test_abort(1'b1, "rst");
    test_start_ignored();
    test_sequence(0, 0, 0, "back_to_back");
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
